wide_add_sequencer: RTL and testbench

Multi-cycle controller that performs a W = N×M-bit add or subtract by time-sharing one N-bit ripple-carry adder slice over M cycles. It holds the carry between slices and accumulates the result slice by slice. It sits between a valid/ready operand source and a valid/ready result sink. Wide arithmetic therefore costs one narrow adder plus registers instead of a W-bit ripple chain.

---
 rtl/wide_add_pkg.sv | 20 ++
 rtl/wide_add_sequencer_if.sv | 29 ++
 rtl/RippleFullAdder.sv | 22 ++
 rtl/wide_add_sequencer.sv | 151 +++++++++++++++
 tb/tb_wide_add_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and width helpers for the slice-serial wide adder.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Full operand width from slice width and slice count.
    function automatic int unsigned calc_w(input int unsigned n, input int unsigned m);
        return n * m;
    endfunction

    // Slice index width; at least one bit so M = 1 still has a counter.
    function automatic int unsigned calc_idx_w(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle between source, sequencer and sink.
interface wide_add_sequencer_if #(
    parameter int unsigned W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         out_ovf;
    logic         busy;

    // Environment side: supplies operands, accepts results.
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_co, out_ovf, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_co, out_ovf, busy
    );
endinterface

// File: rtl/RippleFullAdder.sv
// N-bit ripple-carry chain of full-adder cells (purely combinational).
module RippleFullAdder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum_c,
    output logic         o_co_c
);
    logic [N:0] w_c;

    assign w_c[0] = i_cin;

    // One full-adder cell per bit, carry rippling upward.
    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        assign o_sum_c[gi] = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]   = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_co_c = w_c[N];
endmodule

// File: rtl/wide_add_sequencer.sv
// W = N*M bit add/subtract computed one N-bit slice per cycle on a shared adder.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_sequencer_if.slave  bus
);
    localparam int unsigned W  = calc_w(N, M);
    localparam int unsigned IW = calc_idx_w(M);

    state_e        r_state;
    state_e        w_state_nxt;

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [W-1:0]  w_sum_nxt;
    logic          r_carry;
    logic [IW-1:0] r_idx;

    logic [W-1:0]  r_out_sum;
    logic          r_out_co;
    logic          r_out_ovf;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [31:0]   w_base;
    logic [N-1:0]  w_a_slice;
    logic [N-1:0]  w_b_slice;
    logic [N-1:0]  w_slice_sum;
    logic          w_slice_co;
    logic          w_last;
    logic          w_capture;
    logic          w_step;
    logic          w_finish;

    // Current slice selection feeding the shared adder.
    assign w_base    = 32'(r_idx) * N;
    assign w_a_slice = r_a[w_base +: N];
    assign w_b_slice = r_b[w_base +: N];
    assign w_last    = (r_idx == IW'(M - 1));

    RippleFullAdder #(.N(N)) u_slice_adder (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_cin   (r_carry),
        .o_sum_c (w_slice_sum),
        .o_co_c  (w_slice_co)
    );

    // Accumulated result with the current slice merged in.
    always_comb begin
        w_sum_nxt                = r_sum;
        w_sum_nxt[w_base +: N]   = w_slice_sum;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the current state.
    always_comb begin
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE:    w_capture = bus.in_valid;
            RUN: begin
                w_step   = 1'b1;
                w_finish = w_last;
            end
            default: ;
        endcase
    end

    // Operand capture, slice stepping and carry hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_capture) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_carry <= bus.in_sub ? ~bus.in_cin : bus.in_cin;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_slice_co;
            if (!w_last) begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    // Result registers, loaded on DONE entry and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum <= '0;
            r_out_co  <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if (w_finish) begin
            r_out_sum <= w_sum_nxt;
            r_out_co  <= w_slice_co;
            r_out_ovf <= (r_a[W-1] == r_b[W-1]) && (w_sum_nxt[W-1] != r_a[W-1]);
        end
    end

    // Handshake flags registered from the next state so they track r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_co    = r_out_co;
    assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer at N=4, M=4.
module tb_wide_add_sequencer;
    localparam int unsigned N = 4;
    localparam int unsigned M = 4;
    localparam int unsigned W = N * M;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    wide_add_sequencer_if #(.W(W)) bus ();

    wide_add_sequencer #(.N(N), .M(M)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the W-bit operands, returns {co, ovf, sum}.
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic sub);
        int ua, ub, sa, sb, c, ru, rs;
        logic [17:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = int'(cin);
        if (!sub) begin
            ru = ua + ub + c;
            rs = sa + sb + c;
            res[17] = (ru > 65535);
        end else begin
            ru = ua - ub - c;
            rs = sa - sb - c;
            res[17] = (ru >= 0);
        end
        res[16]   = (rs > 32767) || (rs < -32768);
        res[15:0] = ru[15:0];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_inputs();
        bus.in_valid = 1'($urandom);
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_cin   = 1'($urandom);
        bus.in_sub   = 1'($urandom);
    endtask

    // Issue one operation, optionally stall the result and jam junk inputs.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input int stall, input bit noise);
        logic [17:0] exp;
        int n;
        int lat;
        exp = ref_model(a, b, cin, sub);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq({name, ":ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        check_eq({name, ":busy_run"}, 32'(bus.busy), 32'd1);
        check_eq({name, ":ready_run"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (noise) noise_inputs();
            tick();
            lat++;
        end
        check_eq({name, ":latency"}, 32'(lat), 32'(M));
        check_eq({name, ":sum"}, 32'(bus.out_sum), 32'(exp[15:0]));
        check_eq({name, ":co"}, 32'(bus.out_co), 32'(exp[17]));
        check_eq({name, ":ovf"}, 32'(bus.out_ovf), 32'(exp[16]));
        for (int s = 0; s < stall; s++) begin
            if (noise) noise_inputs();
            tick();
            check_eq({name, ":stall_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({name, ":stall_ready"}, 32'(bus.in_ready), 32'd0);
            check_eq({name, ":stall_result"},
                     {14'd0, bus.out_co, bus.out_ovf, bus.out_sum}, {14'd0, exp});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_eq({name, ":valid_post"}, 32'(bus.out_valid), 32'd0);
        check_eq({name, ":ready_post"}, 32'(bus.in_ready), 32'd1);
        check_eq({name, ":busy_post"}, 32'(bus.busy), 32'd0);
        check_eq({name, ":held_result"},
                 {14'd0, bus.out_co, bus.out_ovf, bus.out_sum}, {14'd0, exp});
    endtask

    task automatic check_reset_values(input string name);
        check_eq({name, ":in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({name, ":out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({name, ":busy"}, 32'(bus.busy), 32'd0);
        check_eq({name, ":out_sum"}, 32'(bus.out_sum), 32'd0);
        check_eq({name, ":out_co"}, 32'(bus.out_co), 32'd0);
        check_eq({name, ":out_ovf"}, 32'(bus.out_ovf), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_cmp = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check_reset_values("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("post_reset");

        do_op("add_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
        do_op("add_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        do_op("stall",      16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 5, 1'b1);

        // Abort mid-RUN once idx has reached 2.
        bus.in_a      = 16'hFFFF;
        bus.in_b      = 16'hFFFF;
        bus.in_cin    = 1'b1;
        bus.in_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_values("abort_after");
        do_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        // Randomized operations with random stalls and junk inputs.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 7 == 0) ra = 16'h8000;
            if (i % 5 == 0) rb = 16'hFFFF;
            do_op("rand", ra, rb, 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
